// File: rtl/bcd_seq_arbiter.sv
// Two-requester round-robin front end feeding a sequential 8-bit
// binary-to-BCD converter (shift-and-add-3, one bit per cycle).
module bcd_seq_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] x0,
  input  logic       req1,
  input  logic [7:0] x1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic       done,
  output logic       owner,
  output logic [3:0] Centenas,
  output logic [3:0] Decenas,
  output logic [3:0] Unidades
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [19:0] work;   // {hundreds, tens, units, operand}
  logic        last;   // requester served most recently
  logic        sel;
  logic [19:0] adj;
  logic [19:0] shifted;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Round-robin pick: on contention the requester not served last wins.
  always_comb begin
    sel = 1'b0;
    if (req0 && req1) sel = ~last;
    else              sel = req1;
  end

  // One shift-and-add-3 step on the working register.
  always_comb begin
    adj     = {add3(work[19:16]), add3(work[15:12]), add3(work[11:8]), work[7:0]};
    shifted = adj << 1;
  end

  // Arbitration, conversion sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      last     <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      owner    <= 1'b0;
      Centenas <= '0;
      Decenas  <= '0;
      Unidades <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            work  <= {12'd0, sel ? x1 : x0};
            cnt   <= '0;
            owner <= sel;
            last  <= sel;
            gnt0  <= ~sel;
            gnt1  <= sel;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt + 4'd1;
          // Eighth step: digits are final in the post-shift nibbles.
          if (cnt == 4'd7) begin
            Centenas <= shifted[19:16];
            Decenas  <= shifted[15:12];
            Unidades <= shifted[11:8];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_arbiter.sv
// Self-checking bench for bcd_seq_arbiter; expected digits come from
// plain decimal arithmetic, grant order from a round-robin pointer model.
module tb_bcd_seq_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [7:0] x0, x1;
  logic       gnt0, gnt1, busy, done, owner;
  logic [3:0] Centenas, Decenas, Unidades;

  int checks = 0;
  int fails  = 0;
  int cyc_g  = 0;

  bcd_seq_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .x0(x0), .req1(req1), .x1(x1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .owner(owner),
    .Centenas(Centenas), .Decenas(Decenas), .Unidades(Unidades)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc_g++;
  endtask

  task automatic check_digits(input int xv, input logic who, input string tag);
    checks++;
    if (Centenas !== 4'(xv / 100) || Decenas !== 4'((xv / 10) % 10) ||
        Unidades !== 4'(xv % 10) || owner !== who) begin
      fails++;
      $display("FAIL %s digits x=%0d: got %0d/%0d/%0d owner=%b, want %0d/%0d/%0d owner=%b",
               tag, xv, Centenas, Decenas, Unidades, owner,
               xv / 100, (xv / 10) % 10, xv % 10, who);
    end
  endtask

  // One full transaction from a single requester, with timing checks.
  task automatic do_conv(input logic who, input int xv, input string tag);
    bit got;
    int n, busy_n;
    if (who) begin req1 = 1'b1; x1 = 8'(xv); end
    else     begin req0 = 1'b1; x0 = 8'(xv); end
    got = 0;
    for (n = 0; n < 20 && !got; n++) begin
      tick();
      if (gnt0 || gnt1) got = 1;
    end
    checks++;
    if (!got || gnt0 !== ~who || gnt1 !== who || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s grant: gnt0=%b gnt1=%b busy=%b, want grant to %0d with busy",
               tag, gnt0, gnt1, busy, who);
    end
    // Drop request and scramble operands: result must not depend on them now.
    req0 = 1'b0; req1 = 1'b0;
    x0 = 8'($urandom); x1 = 8'($urandom);
    busy_n = 1; got = 0; n = 0;
    while (!got && n < 20) begin
      tick(); n++;
      if (done) got = 1;
      else if (busy) busy_n++;
    end
    checks++;
    if (!got || n != 8 || busy_n != 8 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s latency: done after %0d cycles busy=%0d cycles, want 8 and 8", tag, n, busy_n);
    end
    check_digits(xv, who, tag);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      fails++;
      $display("FAIL %s after-done: done=%b busy=%b gnt=%b%b, want all 0", tag, done, busy, gnt0, gnt1);
    end
    check_digits(xv, who, {tag, "-hold"});
  endtask

  task automatic apply_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; x0 = '0; x1 = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({gnt0, gnt1, busy, done, owner, Centenas, Decenas, Unidades} !== 17'd0) begin
      fails++;
      $display("FAIL reset outputs: got %b, want all zero",
               {gnt0, gnt1, busy, done, owner, Centenas, Decenas, Unidades});
    end
  endtask

  task automatic test_single();
    do_conv(1'b0, 255, "x0_255");
    do_conv(1'b1, 0,   "x1_0");
    do_conv(1'b1, 99,  "x1_99");
    do_conv(1'b1, 100, "x1_100");
  endtask

  // Both requesters held high from reset: grants alternate starting at 0.
  task automatic test_round_robin();
    logic last_m, exp_who, who;
    int   xa, xb, prev_done, n;
    bit   got;
    xa = $urandom_range(0, 255); xb = $urandom_range(0, 255);
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; x0 = 8'(xa); x1 = 8'(xb);
    tick(); tick();
    rst = 1'b0;
    last_m = 1'b1; prev_done = -1;
    for (int k = 0; k < 4; k++) begin
      exp_who = ~last_m; last_m = exp_who;
      got = 0;
      for (n = 0; n < 20 && !got; n++) begin tick(); if (gnt0 || gnt1) got = 1; end
      who = gnt1;
      checks++;
      if (!got || (gnt0 && gnt1) || who !== exp_who) begin
        fails++;
        $display("FAIL rr grant %0d: gnt0=%b gnt1=%b, want grant to %0d", k, gnt0, gnt1, exp_who);
      end
      got = 0;
      for (n = 0; n < 20 && !got; n++) begin tick(); if (done) got = 1; end
      check_digits(exp_who ? xb : xa, exp_who, "rr");
      if (prev_done >= 0) begin
        checks++;
        if (!got || cyc_g - prev_done != 9) begin
          fails++;
          $display("FAIL rr spacing %0d: %0d cycles between done pulses, want 9", k, cyc_g - prev_done);
        end
      end
      prev_done = cyc_g;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
  endtask

  // Request 1 arrives mid-conversion; served only after done.
  task automatic test_mid_request();
    int xa, xb, n;
    bit got, early;
    xa = $urandom_range(0, 255); xb = $urandom_range(0, 255);
    req0 = 1'b1; x0 = 8'(xa);
    got = 0;
    for (n = 0; n < 20 && !got; n++) begin tick(); if (gnt0) got = 1; end
    req0 = 1'b0;
    tick(); tick(); tick();
    req1 = 1'b1; x1 = 8'(xb);
    got = 0; early = 0;
    for (n = 0; n < 20 && !got; n++) begin
      tick();
      if (gnt1) early = 1;
      if (done) got = 1;
    end
    check_digits(xa, 1'b0, "mid-conv0");
    tick();
    checks++;
    if (early || !got || gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      fails++;
      $display("FAIL mid gnt1: early=%0d gnt1=%b gnt0=%b after done, want early=0 gnt1=1", early, gnt1, gnt0);
    end
    req1 = 1'b0;
    got = 0;
    for (n = 0; n < 20 && !got; n++) begin tick(); if (done) got = 1; end
    check_digits(xb, 1'b1, "mid-conv1");
    tick();
  endtask

  // Reset during SHIFT aborts: no done, everything zero, then a clean redo.
  task automatic test_reset_abort();
    int n;
    bit seen;
    req0 = 1'b1; x0 = 8'd200;
    seen = 0;
    for (n = 0; n < 20 && !seen; n++) begin tick(); if (gnt0) seen = 1; end
    req0 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({gnt0, gnt1, busy, done, owner, Centenas, Decenas, Unidades} !== 17'd0) begin
      fails++;
      $display("FAIL abort outputs: got %b, want all zero",
               {gnt0, gnt1, busy, done, owner, Centenas, Decenas, Unidades});
    end
    seen = 0;
    for (n = 0; n < 12; n++) begin tick(); if (done || busy) seen = 1; end
    checks++;
    if (seen) begin
      fails++;
      $display("FAIL abort stray: done/busy seen=1 after aborted conversion, want 0");
    end
    do_conv(1'b0, 200, "redo_200");
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++)
      do_conv(1'($urandom), $urandom_range(0, 255), "rand");
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) do_conv(1'b0, v, "sweep");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mid_request();
    test_reset_abort();
    test_random();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/bcd_seq_arbiter.md
BCD_SEQ_ARBITER -- requirements
Module: bcd_seq_arbiter

Interface
- REQ-001: Parameters: none; operand width fixed at 8 bits, result fixed at 3 BCD digits.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst  input  1  reset, synchronous, active-high.
- REQ-004: req0  input  1  requester 0 conversion request; held high until gnt0.
- REQ-005: x0  input  8  requester 0 binary operand; valid while req0 high.
- REQ-006: req1  input  1  requester 1 conversion request; held high until gnt1.
- REQ-007: x1  input  8  requester 1 binary operand; valid while req1 high.
- REQ-008: gnt0  output  1  one-cycle pulse: requester 0 operand accepted.
- REQ-009: gnt1  output  1  one-cycle pulse: requester 1 operand accepted.
- REQ-010: busy  output  1  high while a conversion is in progress.
- REQ-011: done  output  1  one-cycle pulse: result valid on digit outputs.
- REQ-012: owner  output  1  index of requester that owns current/last result.
- REQ-013: Centenas  output  4  BCD hundreds digit.
- REQ-014: Decenas  output  4  BCD tens digit.
- REQ-015: Unidades  output  4  BCD units digit.

Function
- REQ-016: FSM SHALL have states IDLE and SHIFT, plus a 4-bit shift counter and a 20-bit working register (digits[19:8], operand[7:0]).
- REQ-017: At an edge in IDLE with req0 or req1 high, the block SHALL select one requester, load {12'd0, x_sel} into the working register, clear counter, set owner, pulse the matching gnt in the following cycle, and enter SHIFT.
- REQ-018: Arbitration SHALL be round-robin: with both requesting, the requester not served last wins; with one requesting, that one wins.
- REQ-019: After reset, the last-served pointer SHALL be 1, so requester 0 wins the first simultaneous request.
- REQ-020: In SHIFT, each edge SHALL add 3 to every digit nibble [11:8], [15:12], [19:16] that is >= 5, then shift the whole register left by 1 with 0 inserted, and increment the counter.
- REQ-021: On the 8th SHIFT edge, the block SHALL load Centenas/Decenas/Unidades from the post-shift nibbles [19:16]/[15:12]/[11:8], assert done for the following cycle only, and return to IDLE.
- REQ-022: Latency: done SHALL be high in the cycle after the 8th edge following the accept edge; busy SHALL be high for exactly the 8 cycles between accept and done.
- REQ-023: Throughput: a new request SHALL be accepted no earlier than the edge at which done is high; max one conversion per 9 cycles.
- REQ-024: Requests arriving while busy SHALL be ignored (not latched) and SHALL be served once IDLE, subject to round-robin.
- REQ-025: Digit outputs and owner SHALL hold their values between done pulses; operand inputs changing during SHIFT SHALL not affect the result.
- REQ-026: gnt0 and gnt1 SHALL never be high in the same cycle; gnt SHALL never coincide with busy low in IDLE without a prior accept.
- REQ-027: Every digit output SHALL always be in 0..9; Centenas SHALL be in 0..2.

Reset
- REQ-028: While rst is high at an edge, the block SHALL enter IDLE and clear counter, working register, gnt0, gnt1, busy, done, owner, Centenas, Decenas, and Unidades to 0, and set last-served pointer to 1.
- REQ-029: A reset during SHIFT SHALL abort the conversion with no done pulse; a request held through reset SHALL be accepted at the first edge after rst is low.

Verification
- REQ-030: req0=1, x0=255, idle -> gnt0 pulse next cycle, busy 8 cycles, done with Centenas=2, Decenas=5, Unidades=5, owner=0.
- REQ-031: req1=1, x1=0, then x1=99, then x1=100 -> results 0/0/0, 0/9/9, 1/0/0, owner=1 each time.
- REQ-032: req0 and req1 both held high from reset -> grants ordered 0,1,0,1; done pulses spaced 9 cycles apart.
- REQ-033: req1 raised mid-conversion of requester 0 -> no gnt1 until done of conversion 0; gnt1 pulses on the cycle after done.
- REQ-034: rst pulsed at the 4th SHIFT cycle of x0=200 -> no done pulse; all outputs 0; re-request yields 2/0/0.
- REQ-035: Exhaustive sweep of x0 over 0..255 -> every result equals the decimal digits of the operand.
